// File: rtl/ccip_arb_pkg.sv
// Shared definitions for the CCI-P channel 0 read arbiter.
//   - MDATA_ID_W: number of mdata bits that carry the requester ID.
//   - Local copies of the CCI-P header enums and the C0 request header
//     struct. Only the fields this block drives are modelled.
//   - build_rd_hdr(): builds a single-line RDLINE_I request header on VA
//     from a cache-line address and a requester ID.
package ccip_arb_pkg;

  localparam int MDATA_ID_W = 4;
  localparam int CL_ADDR_W  = 42;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
  typedef logic [15:0]          t_ccip_mdata;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  // Fixed header fields for every read this block issues.
  localparam t_ccip_vc     RD_VC_SEL   = eVC_VA;
  localparam t_ccip_clLen  RD_CL_LEN   = eCL_LEN_1;
  localparam t_ccip_c0_req RD_REQ_TYPE = eREQ_RDLINE_I;

  function automatic t_ccip_c0_ReqMemHdr build_rd_hdr(
    input t_ccip_clAddr          addr,
    input logic [MDATA_ID_W-1:0] id
  );
    t_ccip_c0_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = RD_VC_SEL;
    h.cl_len   = RD_CL_LEN;
    h.req_type = RD_REQ_TYPE;
    h.address  = addr;
    h.mdata    = t_ccip_mdata'(id);
    return h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered rotation pointer.
//   clk, rst  : clock, synchronous active-high reset (clears the pointer)
//   req_i     : N request lines
//   en_i      : grant enable; no grant while low
//   advance_i : a grant was consumed this cycle; pointer moves past it
//   gnt_o     : one-hot grant (zero when nothing is granted)
//   idx_o     : binary index of the granted requester
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  input  logic             advance_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  // Search upward from rr_ptr with wrap-around; first valid wins.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    logic             found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (en_i && !found && req_i[jj]) begin
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// Shares CCI-P TX channel 0 (memory reads) among NUM_REQ requesters.
// Round-robin grant, throttled by c0TxAlmFull and an outstanding-read
// credit limit. The requester ID rides in mdata[3:0] and routes the
// matching RX channel 0 response back as a one-hot strobe.
//   clk, rst         : pClk, synchronous active-high reset
//   req_valid/addr   : per-requester read request (addr slice i -> req i)
//   req_ready        : one-hot grant; handshake = valid & ready
//   c0_alm_full      : rx.c0TxAlmFull
//   c0_tx_*          : tx.c0 valid / hdr.address / hdr.mdata (1-cycle latency)
//   c0_rx_*          : RDLINE response valid / mdata / data
//   rsp_valid/data   : one-hot routed response strobe and shared data
//   outstanding      : reads in flight
//   err              : sticky error (response with nothing in flight or bad ID)
module ccip_c0_rd_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 42
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      c0_alm_full,
  output logic                      c0_tx_valid,
  output logic [ADDR_W-1:0]         c0_tx_addr,
  output logic [15:0]               c0_tx_mdata,
  input  logic                      c0_rx_rsp_valid,
  input  logic [15:0]               c0_rx_mdata,
  input  logic [511:0]              c0_rx_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [511:0]              rsp_data,
  output logic [7:0]                outstanding,
  output logic                      err
);

  localparam int       IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  logic                     can_issue;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     hs;
  logic [ADDR_W-1:0]        addr_sel;
  t_ccip_c0_ReqMemHdr       hdr_d;

  logic                     tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0]        tx_addr_q,  tx_addr_d;
  logic [15:0]              tx_mdata_q, tx_mdata_d;
  logic [7:0]               cnt_q,      cnt_d;
  logic                     err_q,      err_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [511:0]             rsp_data_q,  rsp_data_d;

  logic [MDATA_ID_W-1:0]    rx_id;
  logic                     rx_id_ok;
  logic                     unused_bits;

  assign can_issue = !c0_alm_full && (cnt_q < MAX_CNT) && !rst;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .en_i      (can_issue),
    .advance_i (hs),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );

  // The arbiter only grants valid requesters, so any grant is a handshake.
  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) addr_sel = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign hdr_d = build_rd_hdr(t_ccip_clAddr'(addr_sel), MDATA_ID_W'(gnt_idx));

  // Issue stage: the header registers hold their value when idle.
  always_comb begin
    tx_valid_d = hs;
    tx_addr_d  = tx_addr_q;
    tx_mdata_d = tx_mdata_q;
    if (hs) begin
      tx_addr_d  = ADDR_W'(hdr_d.address);
      tx_mdata_d = hdr_d.mdata;
    end
  end

  assign rx_id    = c0_rx_mdata[MDATA_ID_W-1:0];
  assign rx_id_ok = ({1'b0, rx_id} < (MDATA_ID_W + 1)'(NUM_REQ));

  // Credit counter and sticky error. A response with nothing in flight
  // is a protocol error and must not underflow the counter.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({hs, c0_rx_rsp_valid})
      2'b10: if (cnt_q < MAX_CNT) cnt_d = cnt_q + 8'd1;
      2'b01: begin
        if (cnt_q == 8'd0) err_d = 1'b1;
        else               cnt_d = cnt_q - 8'd1;
      end
      2'b11: if (cnt_q == 8'd0) err_d = 1'b1;
      default: ;
    endcase
    if (c0_rx_rsp_valid && !rx_id_ok) err_d = 1'b1;
  end

  // Response routing stage.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (c0_rx_rsp_valid && rx_id_ok) begin
      rsp_valid_d[rx_id] = 1'b1;
      rsp_data_d         = c0_rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q  <= 1'b0;
      tx_addr_q   <= '0;
      tx_mdata_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tx_valid_q  <= tx_valid_d;
      tx_addr_q   <= tx_addr_d;
      tx_mdata_q  <= tx_mdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign c0_tx_valid = tx_valid_q;
  assign c0_tx_addr  = tx_addr_q;
  assign c0_tx_mdata = tx_mdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign outstanding = cnt_q;
  assign err         = err_q;

  // Fixed header fields are implied by the channel; only address and
  // mdata leave this block. Upper rx mdata bits carry no routing info.
  assign unused_bits = ^{hdr_d.vc_sel, hdr_d.cl_len, hdr_d.req_type,
                         hdr_d.rsvd0, c0_rx_mdata[15:MDATA_ID_W]};

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
module tb_ccip_c0_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 42;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic              alm_full;
  logic              rx_valid;
  logic [15:0]       rx_mdata;
  logic [511:0]      rx_data;

  logic [N-1:0]      ready_a, rspv_a;
  logic              txv_a, err_a;
  logic [AW-1:0]     addr_a;
  logic [15:0]       mdata_a;
  logic [511:0]      rdata_a;
  logic [7:0]        out_a;

  logic [N-1:0]      ready_b, rspv_b;
  logic              txv_b, err_b;
  logic [AW-1:0]     addr_b;
  logic [15:0]       mdata_b;
  logic [511:0]      rdata_b;
  logic [7:0]        out_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [511:0] pat;
  logic [AW-1:0] eaddr;

  always #5 clk = ~clk;

  ccip_c0_rd_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(64), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready_a), .c0_alm_full(alm_full), .c0_tx_valid(txv_a),
    .c0_tx_addr(addr_a), .c0_tx_mdata(mdata_a), .c0_rx_rsp_valid(rx_valid),
    .c0_rx_mdata(rx_mdata), .c0_rx_data(rx_data), .rsp_valid(rspv_a),
    .rsp_data(rdata_a), .outstanding(out_a), .err(err_a)
  );

  ccip_c0_rd_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(4), .ADDR_W(AW)) dut_lim (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready_b), .c0_alm_full(alm_full), .c0_tx_valid(txv_b),
    .c0_tx_addr(addr_b), .c0_tx_mdata(mdata_b), .c0_rx_rsp_valid(rx_valid),
    .c0_rx_mdata(rx_mdata), .c0_rx_data(rx_data), .rsp_valid(rspv_b),
    .rsp_data(rdata_b), .outstanding(out_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_addr  = '0;
    alm_full  = 1'b0;
    rx_valid  = 1'b0;
    rx_mdata  = '0;
    rx_data   = '0;
    pat       = {16{32'h1234ABCD}};

    // Reset state, with requests pending while rst is high.
    tick();
    #1;
    chk("rst_ready", 512'(ready_a), 512'(4'b0000));
    chk("rst_txv",   512'(txv_a),   512'(1'b0));
    chk("rst_out",   512'(out_a),   512'(8'd0));
    chk("rst_err",   512'(err_a),   512'(1'b0));
    chk("rst_rspv",  512'(rspv_a),  512'(4'b0000));
    req_valid = '0;
    rst = 1'b0;

    // Single request from requester 1.
    set_addr(1, 42'h1000);
    req_valid = 4'b0010;
    #1;
    chk("single_gnt", 512'(ready_a), 512'(4'b0010));
    tick();
    req_valid = '0;
    chk("single_txv",   512'(txv_a),   512'(1'b1));
    chk("single_addr",  512'(addr_a),  512'(42'h1000));
    chk("single_mdata", 512'(mdata_a), 512'(16'h0001));
    chk("single_out",   512'(out_a),   512'(8'd1));
    tick();
    chk("single_idle_txv",  512'(txv_a),  512'(1'b0));
    chk("single_hold_addr", 512'(addr_a), 512'(42'h1000));

    // Fairness: all four valid for eight cycles from reset.
    do_reset();
    chk("rst2_addr",  512'(addr_a),  512'(42'h0));
    chk("rst2_mdata", 512'(mdata_a), 512'(16'h0));
    chk("rst2_out",   512'(out_a),   512'(8'd0));
    for (int i = 0; i < N; i++) set_addr(i, 42'h100 + 42'(i));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("fair_gnt", 512'(ready_a), 512'(1) << (c % 4));
      if (c >= 4) chk("lim_nogrant", 512'(ready_b), 512'(4'b0000));
      tick();
      eaddr = 42'h100 + 42'(c % 4);
      chk("fair_txv",   512'(txv_a),   512'(1'b1));
      chk("fair_mdata", 512'(mdata_a), 512'(c % 4));
      chk("fair_addr",  512'(addr_a),  512'(eaddr));
    end
    chk("fair_out", 512'(out_a), 512'(8'd8));
    chk("lim_out",  512'(out_b), 512'(8'd4));

    // Response to requester 2; A also handshakes in the same cycle.
    rx_valid = 1'b1;
    rx_mdata = 16'h0002;
    rx_data  = pat;
    #1;
    chk("simul_gnt", 512'(ready_a), 512'(4'b0001));
    chk("lim_full",  512'(ready_b), 512'(4'b0000));
    tick();
    rx_valid = 1'b0;
    chk("simul_out",   512'(out_a),   512'(8'd8));
    chk("simul_txv",   512'(txv_a),   512'(1'b1));
    chk("simul_mdata", 512'(mdata_a), 512'(16'h0000));
    chk("simul_rspv",  512'(rspv_a),  512'(4'b0100));
    chk("lim_out_dec", 512'(out_b),   512'(8'd3));
    chk("lim_rspv",    512'(rspv_b),  512'(4'b0100));
    chk("lim_rdata",   rdata_b,       pat);
    chk("lim_txv0",    512'(txv_b),   512'(1'b0));
    #1;
    chk("lim_regrant", 512'(ready_b), 512'(4'b0001));
    chk("simul_next",  512'(ready_a), 512'(4'b0010));
    tick();
    req_valid = '0;
    chk("lim_out_re", 512'(out_b),   512'(8'd4));
    chk("lim_txv1",   512'(txv_b),   512'(1'b1));
    chk("lim_mdata",  512'(mdata_b), 512'(16'h0000));
    chk("a_out9",     512'(out_a),   512'(8'd9));
    chk("a_mdata1",   512'(mdata_a), 512'(16'h0001));

    // Backpressure via almost-full.
    do_reset();
    req_valid = 4'b1111;
    #1;
    chk("bp_gnt0", 512'(ready_a), 512'(4'b0001));
    tick();
    alm_full = 1'b1;
    #1;
    chk("bp_inflight_txv", 512'(txv_a),   512'(1'b1));
    chk("bp_ready0",       512'(ready_a), 512'(4'b0000));
    tick();
    chk("bp_txv0", 512'(txv_a), 512'(1'b0));
    chk("bp_out",  512'(out_a), 512'(8'd1));
    #1;
    chk("bp_ready_hold", 512'(ready_a), 512'(4'b0000));
    alm_full = 1'b0;
    #1;
    chk("bp_resume", 512'(ready_a), 512'(4'b0010));
    tick();
    req_valid = '0;
    chk("bp_txv1",   512'(txv_a),   512'(1'b1));
    chk("bp_mdata1", 512'(mdata_a), 512'(16'h0001));
    chk("bp_out2",   512'(out_a),   512'(8'd2));

    // Response with nothing outstanding.
    do_reset();
    rx_valid = 1'b1;
    rx_mdata = 16'h0001;
    tick();
    rx_valid = 1'b0;
    chk("zero_err", 512'(err_a), 512'(1'b1));
    chk("zero_out", 512'(out_a), 512'(8'd0));
    do_reset();
    chk("err_clr", 512'(err_a), 512'(1'b0));

    // Out-of-range requester ID.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("badid_pre_out", 512'(out_a), 512'(8'd1));
    rx_valid = 1'b1;
    rx_mdata = 16'h0009;
    tick();
    rx_valid = 1'b0;
    chk("badid_rspv", 512'(rspv_a), 512'(4'b0000));
    chk("badid_err",  512'(err_a),  512'(1'b1));
    chk("badid_out",  512'(out_a),  512'(8'd0));
    tick();
    chk("err_sticky", 512'(err_a), 512'(1'b1));

    // Reset in the middle of a burst with a response arriving.
    do_reset();
    req_valid = 4'b1111;
    tick();
    tick();
    chk("burst_out", 512'(out_a), 512'(8'd2));
    rx_valid = 1'b1;
    rx_mdata = 16'h0003;
    rx_data  = pat;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 512'(ready_a), 512'(4'b0000));
    tick();
    rst = 1'b0;
    rx_valid = 1'b0;
    req_valid = '0;
    chk("mid_rst_txv",   512'(txv_a),   512'(1'b0));
    chk("mid_rst_rspv",  512'(rspv_a),  512'(4'b0000));
    chk("mid_rst_out",   512'(out_a),   512'(8'd0));
    chk("mid_rst_err",   512'(err_a),   512'(1'b0));
    chk("mid_rst_addr",  512'(addr_a),  512'(42'h0));
    chk("mid_rst_mdata", 512'(mdata_a), 512'(16'h0));
    chk("mid_rst_rdata", rdata_a,       512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccip_c0_rd_arbiter.md
Name: ccip_c0_rd_arbiter

Overview:
- Shares CCI-P TX channel 0 (memory read requests) among NUM_REQ AFU-internal requesters. Arbitration is round-robin.
- Throttles issue on c0TxAlmFull and on an outstanding-read credit limit.
- Tags each request's mdata with the requester ID and routes RX channel 0 read responses back to the originating requester.
- Sits inside afu, between internal engines and the registered CCI-P rx/tx structures.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_OUTSTANDING, 64, maximum reads in flight (1..255).
- ADDR_W, 42, cache-line address width (CCI-P t_ccip_clAddr).

Ports:
- clk  in  1  sole clock, pClk domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_addr  in  NUM_REQ*ADDR_W  per-requester cache-line address; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot grant. Handshake completes when req_valid[i] & req_ready[i].
- c0_alm_full  in  1  rx.c0TxAlmFull.
- c0_tx_valid  out  1  tx.c0.valid.
- c0_tx_addr  out  ADDR_W  tx.c0.hdr.address.
- c0_tx_mdata  out  16  tx.c0.hdr.mdata. Bits [3:0] carry the requester ID; bits [15:4] are 0.
- c0_rx_rsp_valid  in  1  rx.c0.rspValid & (hdr.resp_type == eRSP_RDLINE).
- c0_rx_mdata  in  16  rx.c0.hdr.mdata.
- c0_rx_data  in  512  rx.c0.data.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  512  response data, shared by all requesters.
- outstanding  out  8  reads currently in flight.
- err  out  1  sticky protocol error.

Behaviour:
- Fixed request fields: req_type eREQ_RDLINE_I, cl_len eCL_LEN_1, vc_sel eVC_VA. All other header fields are 0.
- can_issue = !c0_alm_full & (outstanding < MAX_OUTSTANDING) & !rst.
- Grant (combinational):
  - When can_issue is high, req_ready is one-hot on the first valid requester at or after rr_ptr, searching upward with wrap-around.
  - When can_issue is low, req_ready = 0.
  - req_ready never asserts for a requester whose req_valid is low.
- rr_ptr updates on a handshake with requester g: rr_ptr <= (g+1) mod NUM_REQ. With no handshake it holds.
- Issue latency: 1 cycle. On the cycle after the handshake, c0_tx_valid = 1, c0_tx_addr = captured address, c0_tx_mdata = {12'h0, g}. Otherwise c0_tx_valid = 0; addr/mdata hold their last values.
- Throughput: at most one issue per cycle, back-to-back issue allowed.
- c0_alm_full rising mid-stream: a request granted in the cycle before the rise is still issued. CCI-P almost-full slack covers this. No grant occurs while alm_full is high.
- Outstanding counter:
  - +1 on handshake, -1 on c0_rx_rsp_valid; both in the same cycle leaves it unchanged.
  - Saturates at MAX_OUTSTANDING. No grant is made at the limit, so a grant always leaves it ≤ MAX.
  - A response arriving at 0 sets err; the counter stays 0.
- Response routing (1-cycle registered):
  - id = c0_rx_mdata[3:0].
  - If id < NUM_REQ: next cycle rsp_valid[id] = 1 and rsp_data = c0_rx_data.
  - If id ≥ NUM_REQ: nothing is routed, err is set, and the counter still decrements.
  - Only one response per cycle is possible, so rsp_valid is always one-hot or 0.
- Requesters must accept responses unconditionally. There is no backpressure on the response path.
- Reset (synchronous, applied whenever rst is high, including mid-operation):
  - Cleared: c0_tx_valid, req_ready, rsp_valid, outstanding, err, rr_ptr, c0_tx_addr, c0_tx_mdata, rsp_data.
  - Responses to reads in flight before reset arrive at count 0 and set err. Softreset on CCI-P guarantees none arrive, so this path is a checker only.

Decomposition:
- Package ccip_arb_pkg holds:
  - MDATA_ID_W = 4.
  - Fixed header constants.
  - Function to build t_ccip_c0_ReqMemHdr from addr and id.
- afu unpacks the rx/tx structs; this block uses flat ports.
- Sub-module rr_arbiter (parameter N): inputs req, en, advance; outputs one-hot gnt and idx. Contains rr_ptr. Reusable later for the C1 write arbiter.

Test Plan:
- Single request: req_valid=4'b0010, addr=42'h1000 -> cycle 0 req_ready=4'b0010; cycle 1 c0_tx_valid=1, addr=42'h1000, mdata=16'h0001; outstanding=1.
- Fairness: all 4 valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; 8 consecutive issues; outstanding=8.
- Backpressure: c0_alm_full=1 with requests pending -> req_ready=0 and c0_tx_valid=0 from the next cycle. Release -> granting resumes at rr_ptr.
- Credit limit (MAX_OUTSTANDING=4): 4 issues then no grant. One response with mdata=2 -> rsp_valid=4'b0100 next cycle with data; outstanding drops to 3 and the next grant is allowed in the same cycle the count drops.
- Simultaneous handshake + response -> outstanding unchanged; c0_tx_valid and rsp_valid both assert next cycle.
- Errors: response with mdata=16'h0009 (NUM_REQ=4) -> no rsp_valid, err=1 sticky. Response at outstanding=0 -> err=1, count stays 0. rst mid-burst -> all outputs 0 on the next cycle.
